// File: rtl/ram_wb_pkg.sv
// Shared encodings for the Wishbone B3 RAM slave: cycle/burst types, FSM states, log2 helper.
package ram_wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLASSIC,
    ST_BURST,
    ST_ERR
  } state_e;

  // ceil(log2(v)); 0 for v <= 1
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/ram_wb_b3_mem.sv
// Single-port synchronous RAM with per-byte write enables; read data registered.
module ram_wb_b3_mem #(
  parameter int unsigned DW          = 32,
  parameter int unsigned DEPTH       = 5120,
  parameter int unsigned ABITS       = 13,
  parameter string       MEMORY_FILE = ""
) (
  input  logic              clk,
  input  logic              en,
  input  logic [DW/8-1:0]   we,
  input  logic [ABITS-1:0]  addr,
  input  logic [DW-1:0]     din,
  output logic [DW-1:0]     dout
);

  logic [DW-1:0] mem [DEPTH];

  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  // dout only refreshes on read accesses so it keeps the last read word
  always_ff @(posedge clk) begin
    if (en) begin
      for (int unsigned b = 0; b < DW/8; b++) begin
        if (we[b]) mem[addr][b*8 +: 8] <= din[b*8 +: 8];
      end
      if (we == '0) dout <= mem[addr];
    end
  end

endmodule

// File: rtl/ram_wb_b3.sv
// Wishbone B3 RAM slave with classic and registered-feedback burst cycles.
module ram_wb_b3
  import ram_wb_pkg::*;
#(
  parameter int unsigned DW          = 32,
  parameter int unsigned DEPTH       = 5120,
  parameter int unsigned AW          = 32,
  parameter string       MEMORY_FILE = ""
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic [AW-1:0]     wb_adr_i,
  input  logic [DW-1:0]     wb_dat_i,
  input  logic [DW/8-1:0]   wb_sel_i,
  input  logic              wb_we_i,
  input  logic [2:0]        wb_cti_i,
  input  logic [1:0]        wb_bte_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic              wb_rty_o,
  output logic [DW-1:0]     wb_dat_o
);

  localparam int unsigned OFFW = clog2(DW/8);
  localparam int unsigned IW   = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;

  state_e          state_q, state_d;
  logic            ack_q, ack_d, err_q, err_d;
  logic            rdv_q, rdv_d, ready_q, ready_d;
  logic [IW-1:0]   adr_q, adr_d;
  logic [AW-1:0]   idx;
  logic            in_range, req, take, ok;
  logic            mem_en;
  logic [DW/8-1:0] mem_we;
  logic [DW-1:0]   mem_dout;

  function automatic logic [IW-1:0] next_adr(input logic [IW-1:0] cur,
                                             input logic [2:0] cti,
                                             input logic [1:0] bte);
    logic [IW-1:0] mask, inc;
    inc = cur + IW'(1);
    case (bte)
      BTE_WRAP4:  mask = IW'(3);
      BTE_WRAP8:  mask = IW'(7);
      BTE_WRAP16: mask = IW'(15);
      default:    mask = '1;
    endcase
    if (cti == CTI_CONST) return cur;
    return (cur & ~mask) | (inc & mask);
  endfunction

  assign idx      = wb_adr_i >> OFFW;
  assign in_range = 64'(idx) < 64'(DEPTH);
  // ready_q delays acceptance one edge so reset release is seen synchronously
  assign req      = wb_cyc_i & wb_stb_i & ready_q;

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    adr_d   = adr_q;
    rdv_d   = rdv_q;
    ready_d = 1'b1;
    take    = 1'b0;
    ok      = 1'b0;
    mem_en  = 1'b0;
    mem_we  = '0;
    if (!wb_cyc_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (req) begin
          take = 1'b1;
          ok   = in_range;
          if (wb_cti_i == CTI_CONST || wb_cti_i == CTI_INCR)
            state_d = in_range ? ST_BURST : ST_ERR;
          else
            state_d = ST_CLASSIC;
        end
        ST_CLASSIC: state_d = ST_IDLE;
        ST_BURST: if (req) begin
          take = 1'b1;
          ok   = in_range && (idx == AW'(adr_q));
          if (!ok)                       state_d = ST_ERR;
          else if (wb_cti_i == CTI_EOB)  state_d = ST_IDLE;
        end
        ST_ERR: ;
      endcase
    end
    if (take) begin
      ack_d = ok;
      err_d = ~ok;
      if (ok) begin
        mem_en = 1'b1;
        mem_we = wb_we_i ? wb_sel_i : '0;
        adr_d  = next_adr(IW'(idx), wb_cti_i, wb_bte_i);
        if (!wb_we_i) rdv_d = 1'b1;
      end else begin
        rdv_d = 1'b0;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      adr_q   <= '0;
      rdv_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      adr_q   <= adr_d;
      rdv_q   <= rdv_d;
      ready_q <= ready_d;
    end
  end

  ram_wb_b3_mem #(
    .DW          (DW),
    .DEPTH       (DEPTH),
    .ABITS       (IW),
    .MEMORY_FILE (MEMORY_FILE)
  ) u_mem (
    .clk  (wb_clk_i),
    .en   (mem_en),
    .we   (mem_we),
    .addr (IW'(idx)),
    .din  (wb_dat_i),
    .dout (mem_dout)
  );

  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_rty_o = 1'b0;
  assign wb_dat_o = rdv_q ? mem_dout : '0;

endmodule

// File: tb/tb_ram_wb_b3.sv
// Directed bench for ram_wb_b3: a default-depth instance and a 16-word instance share one bus.
module tb_ram_wb_b3;

  logic        clk, rst_n;
  logic [31:0] adr, dat_i;
  logic [3:0]  sel;
  logic        we, cyc, stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack, err, rty, ack_s, err_s, rty_s;
  logic [31:0] dat_o, dat_s;

  int n_checks = 0;
  int n_errors = 0;

  logic        c_pre, c_ack, c_err, c_post, c_ack_s, c_err_s, c_post_s;
  logic [31:0] c_dat, c_dat_s;

  logic [31:0] wrap_exp [4] = '{32'h3, 32'h4, 32'h1, 32'h2};
  logic [31:0] wrap_adr [3] = '{32'h2C, 32'h20, 32'h24};

  ram_wb_b3 #(.DW(32), .DEPTH(5120), .AW(32), .MEMORY_FILE("")) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_adr_i(adr), .wb_dat_i(dat_i),
    .wb_sel_i(sel), .wb_we_i(we), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_ack_o(ack), .wb_err_o(err),
    .wb_rty_o(rty), .wb_dat_o(dat_o)
  );

  ram_wb_b3 #(.DW(32), .DEPTH(16), .AW(32), .MEMORY_FILE("")) dut_s (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_adr_i(adr), .wb_dat_i(dat_i),
    .wb_sel_i(sel), .wb_we_i(we), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_ack_o(ack_s), .wb_err_o(err_s),
    .wb_rty_o(rty_s), .wb_dat_o(dat_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // classic master: stb held through the ack edge, then dropped
  task automatic classic(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    cti = 3'b000; bte = 2'b00;
    c_pre = ack | err;
    @(negedge clk);
    c_ack = ack; c_err = err; c_dat = dat_o;
    c_ack_s = ack_s; c_err_s = err_s; c_dat_s = dat_s;
    @(negedge clk);
    c_post = ack | err; c_post_s = ack_s | err_s;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_i = '0;
    sel = '0; cti = '0; bte = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rty", 32'(rty), 32'd0);
    check("rst_dat", dat_o, 32'd0);

    // release reset with a read already pending: accepted on the second edge
    repeat (2) @(negedge clk);
    rst_n = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0;
    @(negedge clk);
    check("rel_edge1_ack", 32'(ack), 32'd0);
    @(negedge clk);
    check("rel_edge2_ack", 32'(ack), 32'd1);
    check("rel_dat", dat_o, 32'd0);
    cyc = 1'b0; stb = 1'b0;

    // classic write then read
    classic(1'b1, 32'h40, 32'hA5A5_1234, 4'hF);
    check("cw_pre", 32'(c_pre), 32'd0);
    check("cw_ack", 32'(c_ack), 32'd1);
    check("cw_err", 32'(c_err), 32'd0);
    check("cw_post", 32'(c_post), 32'd0);
    classic(1'b0, 32'h40, 32'h0, 4'hF);
    check("cr_ack", 32'(c_ack), 32'd1);
    check("cr_dat", c_dat, 32'hA5A5_1234);
    check("cr_post", 32'(c_post), 32'd0);
    classic(1'b0, 32'h43, 32'h0, 4'hF);
    check("cr_offset_dat", c_dat, 32'hA5A5_1234);

    // byte-select write
    classic(1'b1, 32'h40, 32'hFFFF_FFFF, 4'hF);
    classic(1'b1, 32'h40, 32'h0000_0000, 4'b0101);
    classic(1'b0, 32'h40, 32'h0, 4'hF);
    check("bw_dat", c_dat, 32'hFF00_FF00);

    // 4-beat wrap read starting mid-block
    for (int k = 0; k < 4; k++) classic(1'b1, 32'h20 + 32'(4*k), 32'(k+1), 4'hF);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; cti = 3'b010; bte = 2'b01; adr = 32'h28;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("wrap_ack", 32'(ack), 32'd1);
      check("wrap_dat", dat_o, wrap_exp[i]);
      if (i < 3) begin
        adr = wrap_adr[i];
        cti = (i == 2) ? 3'b111 : 3'b010;
      end else begin
        cyc = 1'b0; stb = 1'b0; cti = 3'b000; bte = 2'b00;
      end
    end
    @(negedge clk);
    check("wrap_end_ack", 32'(ack), 32'd0);

    // burst with a strobe gap: ack drops, address holds
    cyc = 1'b1; stb = 1'b1; we = 1'b0; cti = 3'b010; bte = 2'b00; adr = 32'h20;
    @(negedge clk);
    check("pause_b1_dat", dat_o, 32'h1);
    stb = 1'b0;
    @(negedge clk);
    check("pause_gap_ack", 32'(ack), 32'd0);
    stb = 1'b1; adr = 32'h24; cti = 3'b111;
    @(negedge clk);
    check("pause_b2_ack", 32'(ack), 32'd1);
    check("pause_b2_dat", dat_o, 32'h2);
    cyc = 1'b0; stb = 1'b0; cti = 3'b000;

    // address mismatch on beat 2 of a linear write burst
    classic(1'b1, 32'h14, 32'h0000_0055, 4'hF);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; cti = 3'b010; bte = 2'b00;
    adr = 32'h0; dat_i = 32'h1111_1111; sel = 4'hF;
    @(negedge clk);
    check("mm_b1_ack", 32'(ack), 32'd1);
    adr = 32'h14; dat_i = 32'hDEAD_BEEF;
    @(negedge clk);
    check("mm_b2_ack", 32'(ack), 32'd0);
    check("mm_b2_err", 32'(err), 32'd1);
    stb = 1'b0; we = 1'b0;
    @(negedge clk);
    check("mm_err_drop", 32'(err), 32'd0);
    stb = 1'b1; cti = 3'b000;
    @(negedge clk);
    check("mm_errstate_ack", 32'(ack), 32'd0);
    check("mm_errstate_err", 32'(err), 32'd0);
    cyc = 1'b0; stb = 1'b0;
    classic(1'b0, 32'h14, 32'h0, 4'hF);
    check("mm_idle_ack", 32'(c_ack), 32'd1);
    check("mm_target_dat", c_dat, 32'h0000_0055);
    classic(1'b0, 32'h0, 32'h0, 4'hF);
    check("mm_beat1_dat", c_dat, 32'h1111_1111);

    // out-of-range on the 16-word instance
    classic(1'b1, 32'h40, 32'hBAD0_BAD0, 4'hF);
    check("oor_w_err", 32'(c_err_s), 32'd1);
    check("oor_w_ack", 32'(c_ack_s), 32'd0);
    check("oor_w_dat", c_dat_s, 32'd0);
    check("oor_w_post", 32'(c_post_s), 32'd0);
    classic(1'b0, 32'h0, 32'h0, 4'hF);
    check("oor_alias_dat", c_dat_s, 32'h1111_1111);
    classic(1'b0, 32'h40, 32'h0, 4'hF);
    check("oor_r_err", 32'(c_err_s), 32'd1);
    check("oor_r_dat", c_dat_s, 32'd0);
    check("big_r_dat", c_dat, 32'hBAD0_BAD0);

    // reset on beat 3 of an 8-beat write burst
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; cti = 3'b010; bte = 2'b00;
    adr = 32'h80; dat_i = 32'hB000_0001; sel = 4'hF;
    @(negedge clk);
    check("rb_b1_ack", 32'(ack), 32'd1);
    adr = 32'h84; dat_i = 32'hB000_0002;
    @(negedge clk);
    check("rb_b2_ack", 32'(ack), 32'd1);
    adr = 32'h88; dat_i = 32'hB000_0003;
    rst_n = 1'b0;
    #1;
    check("rb_ack_drop", 32'(ack), 32'd0);
    check("rb_dat_zero", dat_o, 32'd0);
    @(negedge clk);
    check("rb_hold_ack", 32'(ack), 32'd0);
    adr = 32'h8C; dat_i = 32'hB000_0004;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
    rst_n = 1'b1;
    classic(1'b0, 32'h80, 32'h0, 4'hF);
    check("rb_idle_ack", 32'(c_ack), 32'd1);
    check("rb_w1_dat", c_dat, 32'hB000_0001);
    classic(1'b0, 32'h84, 32'h0, 4'hF);
    check("rb_w2_dat", c_dat, 32'hB000_0002);
    classic(1'b0, 32'h88, 32'h0, 4'hF);
    check("rb_w3_dat", c_dat, 32'h0);
    classic(1'b0, 32'h8C, 32'h0, 4'hF);
    check("rb_w4_dat", c_dat, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_wb_b3.md
RAM_WB_B3 -- requirements
Module: ram_wb_b3

Interface
REQ-001 SHALL have parameter DW, default 32, data width in bits; legal values 32, 64, 128.
REQ-002 SHALL have parameter DEPTH, default 5120, memory size in DW-bit words.
REQ-003 SHALL have parameter AW, default 32, byte address width.
REQ-004 SHALL have parameter MEMORY_FILE, default "", hex init file; empty means zero-fill.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 SHALL have the following ports:
- wb_clk_i  in  1  clock
- wb_rst_ni  in  1  async active-low reset
- wb_adr_i  in  AW  byte address
- wb_dat_i  in  DW  write data
- wb_sel_i  in  DW/8  byte selects
- wb_we_i  in  1  write enable
- wb_cti_i  in  3  cycle type
- wb_bte_i  in  2  burst type
- wb_cyc_i  in  1  cycle
- wb_stb_i  in  1  strobe
- wb_ack_o  out  1  acknowledge
- wb_err_o  out  1  error
- wb_rty_o  out  1  retry, tied 0
- wb_dat_o  out  DW  read data

Function
REQ-007 SHALL derive word index = wb_adr_i >> log2(DW/8); the low byte-offset bits SHALL be ignored.
REQ-008 SHALL write only the bytes whose wb_sel_i bit is 1, using native per-byte write enables and no read-modify-write.
REQ-009 SHALL implement the FSM states IDLE, CLASSIC, BURST and ERR.
REQ-010 IDLE with cyc&stb and cti=000 or 111 SHALL go to CLASSIC, with ack asserted for exactly one cycle, one cycle after the strobe is sampled; a read SHALL present data in the ack cycle.
REQ-011 CLASSIC SHALL return to IDLE after the ack and SHALL NOT ack again until stb has been sampled low, or a new strobe is presented after the ack.
REQ-012 IDLE with cyc&stb and cti=001 or 010 SHALL go to BURST, with the first ack one cycle later.
REQ-013 In BURST, SHALL assert ack every cycle stb is high, advance the internal address on each ack, and prefetch so that each read beat has zero wait states.
REQ-014 Address advance SHALL follow bte, applied to the word index: 00 linear +1; 01, 10 and 11 wrap within aligned 4, 8 and 16 words, with high bits held.
REQ-015 A cti=001 burst SHALL hold the address constant.
REQ-016 In BURST, stb low SHALL deassert ack in the next cycle and hold the address; the burst SHALL resume when stb returns high.
REQ-017 A beat with cti=111 SHALL be the final ack; the FSM SHALL then go to IDLE.
REQ-018 A BURST beat whose wb_adr_i word index differs from the internal address SHALL assert err instead of ack, suppress the write, and go to ERR.
REQ-019 Any access with word index >= DEPTH SHALL assert err for one cycle (same timing as ack), suppress the write, and return wb_dat_o = 0.
REQ-020 ERR SHALL hold ack and err low and return to IDLE when cyc is low.
REQ-021 cyc low in any state SHALL force IDLE within one cycle and drop ack/err.
REQ-022 Ack and err SHALL never be asserted in the same cycle.
REQ-023 Linear address increment SHALL wrap modulo 2^ceil(log2(DEPTH)); a resulting index >= DEPTH SHALL be handled per REQ-019.

Reset
REQ-024 Reset asserted SHALL immediately force IDLE and ack=0, err=0, internal burst address=0; wb_dat_o SHALL be 0 until the first read.
REQ-025 Reset mid-burst SHALL abort the burst with no further writes; memory contents SHALL be preserved.
REQ-026 Deassertion SHALL be used synchronously; the first access SHALL be accepted on the second rising edge after release.

Structure
REQ-027 Package ram_wb_pkg SHALL hold the cti/bte encodings, the FSM state enum and the log2 helper function.
REQ-028 Sub-module ram_wb_b3_mem SHALL be a single-port synchronous RAM with DW/8 byte enables, synthesisable as block RAM and initialised from MEMORY_FILE.

Verification
REQ-029 Classic write then read: write 0xA5A5_1234 with sel=1111 to 0x40, then read 0x40 -> read returns 0xA5A5_1234; each ack is 1 cycle wide and 1 cycle after stb.
REQ-030 Byte write: word 0x10 holds 0xFFFF_FFFF; write 0x0000_0000 with sel=0101, then read 0x10 -> 0xFF00_FF00.
REQ-031 4-beat wrap read: fill words 0x8..0xB with 0x1..0x4; read burst starting at byte 0x28 (word 0xA) with cti=010, bte=01 -> data 0x3, 0x4, 0x1, 0x2 on 4 consecutive acks, last beat cti=111.
REQ-032 Address mismatch: linear burst from word 0, master presents word 5 on beat 2 -> err on that beat, no ack, target memory unchanged, FSM returns to IDLE after cyc low.
REQ-033 Out-of-range: DEPTH=16, write to word 16 -> err one cycle after stb, memory unchanged, wb_dat_o=0.
REQ-034 Reset mid-burst: assert wb_rst_ni low on beat 3 of an 8-beat write burst -> ack drops immediately, beats 1-2 are retained, beat 3 onward is not written, FSM is in IDLE.
